// File: rtl/mil_std_1553_tx_if.sv
// Host-side word stream into the 1553 transmitter.
// master drives tdata/tuser/tvalid, slave returns tready.
interface mil_std_1553_tx_if;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tuser,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tuser,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/mil_std_1553_tx.sv
// Buffered MIL-STD-1553 Manchester-II word transmitter.
// Ports: clk, rst (sync, active-high), s_axis (slave: tdata,
// tuser, tvalid, tready), data[1:0] bus pair (zz when idle),
// busy, fifo_count; loopback_err when
// MIL_STD_1553_TX_LOOPBACK_CHECK_EN is defined.
module mil_std_1553_tx #(
  parameter int CLOCK_SPEED = 20000000,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_HALF    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  mil_std_1553_tx_if.slave              s_axis,
  inout  wire  [1:0]                    data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
  ,
  output logic                          loopback_err
`endif
);

  localparam int HALF = CLOCK_SPEED / 2000000;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GLEN = (GAP_HALF * HALF > 0) ?
                        GAP_HALF * HALF : 1;
  localparam int GW   = (GLEN > 1) ? $clog2(GLEN) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SYNC, DATA, PARITY, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [5:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   sh_q, sh_d;
  logic          cmd_q, cmd_d;
  logic          par_q, par_d;

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [16:0]   head;
  logic          push, pop, hend;
  logic          drv_en, plus;
  logic [1:0]    drv;

`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
  logic err_q, err_d;
  assign loopback_err = err_q;
`endif

  assign s_axis.s_axis_tready = (cnt_q != CW'(FIFO_DEPTH));
  assign push = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
  assign head = mem_q[rd_q];
  assign fifo_count = cnt_q;
  assign busy = (state_q != IDLE) || (cnt_q != '0);
  assign hend = (hc_q == HW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {s_axis.s_axis_tuser, s_axis.s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      cmd_q   <= 1'b0;
      par_q   <= 1'b0;
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      cmd_q   <= cmd_d;
      par_q   <= par_d;
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // idx_q counts half-bits across the frame:
  // 0-5 sync, 6-37 data, 38-39 parity.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    cmd_d   = cmd_q;
    par_d   = par_q;
    pop     = 1'b0;
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) state_d = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        sh_d    = head[15:0];
        cmd_d   = head[16];
        par_d   = ~^head[15:0];
        hc_d    = '0;
        idx_d   = '0;
        state_d = SYNC;
      end
      SYNC, DATA, PARITY: begin
        hc_d = hend ? '0 : hc_q + 1'b1;
        if (hend) begin
          idx_d = idx_q + 1'b1;
          if (state_q == DATA && idx_q[0])
            sh_d = {sh_q[14:0], 1'b0};
          if (idx_q == 6'd5)  state_d = DATA;
          if (idx_q == 6'd37) state_d = PARITY;
          // Pop the next word on the last parity cycle so
          // its sync follows with no dead time.
          if (idx_q == 6'd39) begin
            if (cnt_q != '0) begin
              pop     = 1'b1;
              sh_d    = head[15:0];
              cmd_d   = head[16];
              par_d   = ~^head[15:0];
              idx_d   = '0;
              state_d = SYNC;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GLEN - 1)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
    if (drv_en && hc_q == HW'(HALF / 2) && data != drv) begin
      err_d   = 1'b1;
      pop     = 1'b0;
      gap_d   = '0;
      state_d = GAP;
    end
`endif
  end

  always_comb begin
    drv_en = 1'b0;
    plus   = 1'b0;
    unique case (1'b1)
      state_q == SYNC: begin
        drv_en = 1'b1;
        plus   = ((idx_q < 6'd3) == cmd_q);
      end
      state_q == DATA: begin
        drv_en = 1'b1;
        plus   = sh_q[15] ^ idx_q[0];
      end
      state_q == PARITY: begin
        drv_en = 1'b1;
        plus   = par_q ^ idx_q[0];
      end
      default: ;
    endcase
  end

  assign drv  = plus ? 2'b10 : 2'b01;
  assign data = drv_en ? drv : 2'bzz;

endmodule

// File: tb/tb_mil_std_1553_tx.sv
// Self-checking bench for mil_std_1553_tx.
// Decodes the bus pair and scores words against a queue model.
module tb_mil_std_1553_tx;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [1:0] data;
  logic       busy;
  logic [3:0] fifo_count;
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
  logic       loopback_err;
`endif

  always #5 clk = ~clk;

  mil_std_1553_tx_if bus ();

  mil_std_1553_tx #(
    .CLOCK_SPEED(20000000),
    .FIFO_DEPTH (8),
    .GAP_HALF   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (bus),
    .data      (data),
    .busy      (busy),
    .fifo_count(fifo_count)
`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
    ,
    .loopback_err(loopback_err)
`endif
  );

  typedef struct packed {
    logic [15:0] w;
    logic        c;
    logic        p;
    logic        sok;
    logic        cok;
  } rx_t;

  typedef struct {
    logic [15:0] d;
    logic        u;
    logic        p;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  rx_t         rx_q[$];
  bit          saw_full = 0;

  // monitor state
  logic        sym [40];
  int          halves = 0;
  int          pos = 0;
  int          run = 0;
  int          zc = 0;
  int          last_run = 0;
  int          last_gap = 0;
  int          gap_busy = 0;

  function automatic bit drv(input logic [1:0] v);
    return (v === 2'b10) || (v === 2'b01);
  endfunction

  function automatic rx_t decode();
    rx_t r;
    logic cs, ds;
    cs = sym[0] & sym[1] & sym[2] &
         !sym[3] & !sym[4] & !sym[5];
    ds = !sym[0] & !sym[1] & !sym[2] &
         sym[3] & sym[4] & sym[5];
    r.c   = cs;
    r.sok = cs | ds;
    r.cok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r.w[15-i] = sym[6+2*i];
      if (sym[6+2*i] == sym[7+2*i]) r.cok = 1'b0;
    end
    r.p = sym[38];
    if (sym[38] == sym[39]) r.cok = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      halves = 0;
      pos    = 0;
      run    = 0;
    end else if (drv(data)) begin
      if (run == 0) begin
        last_gap = zc;
        zc = 0;
      end
      if (pos == HALF / 2) begin
        sym[halves] = (data === 2'b10);
        halves++;
      end
      pos = (pos == HALF - 1) ? 0 : pos + 1;
      run++;
      if (halves == 40 && pos == 0) begin
        rx_q.push_back(decode());
        halves = 0;
      end
    end else begin
      if (run > 0) begin
        last_run = run;
        run      = 0;
        gap_busy = 0;
        halves   = 0;
        pos      = 0;
      end
      zc++;
      if (busy) gap_busy++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic u);
    int w = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tuser  = u;
    bus.s_axis_tvalid = 1'b1;
    while (1) begin
      chk("tready vs count", bus.s_axis_tready,
          32'(fifo_count != 4'd8));
      if (fifo_count == 4'd8) saw_full = 1;
      if (bus.s_axis_tready || w > 2000) break;
      @(negedge clk);
      w++;
    end
    chk("push accepted", bus.s_axis_tready, 1);
    if (bus.s_axis_tready) exp_q.push_back({u, d});
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int mx);
    int n = 0;
    while (busy && n < mx) begin
      @(negedge clk);
      n++;
    end
    chk("idle reached", busy, 0);
  endtask

  task automatic wait_drv(input int mx);
    int n = 0;
    while (!drv(data) && n < mx) begin
      @(negedge clk);
      n++;
    end
    chk("bus driven", drv(data), 1);
  endtask

  task automatic wait_rel(input int mx);
    int n = 0;
    while (drv(data) && n < mx) begin
      @(negedge clk);
      n++;
    end
    chk("bus released", drv(data), 0);
  endtask

  task automatic drain(input int n);
    rx_t r;
    logic [16:0] e;
    chk("rx count", rx_q.size(), n);
    while (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx extra: got %0h want none", r.w);
        continue;
      end
      e = exp_q.pop_front();
      chk("rx sync ok", r.sok, 1);
      chk("rx manchester", r.cok, 1);
      chk("rx word", r.w, e[15:0]);
      chk("rx sync type", r.c, e[16]);
      chk("rx parity", r.p,
          32'(($countones(e[15:0]) % 2) == 0));
    end
    chk("model empty", exp_q.size(), 0);
  endtask

  vec_t tbl[5];
  rx_t  r;
  int   bad;

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    tbl[0] = '{16'h8001, 1'b1, 1'b1};
    tbl[1] = '{16'h1234, 1'b0, 1'b0};
    tbl[2] = '{16'h0007, 1'b1, 1'b0};
    tbl[3] = '{16'hA5A5, 1'b0, 1'b1};
    tbl[4] = '{16'hFFFF, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset bus", drv(data), 0);
    chk("reset tready", bus.s_axis_tready, 1);
    chk("reset busy", busy, 0);
    chk("reset count", fifo_count, 0);

    // single words from the table
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].d, tbl[i].u);
      if (i == 0) begin
        chk("latency +0", drv(data), 0);
        @(negedge clk);
        chk("latency +1", drv(data), 0);
        @(negedge clk);
        chk("latency +2", data, 2'b10);
        bad = 0;
        for (int j = 1; j < 60; j++) begin
          @(negedge clk);
          if (data !== ((j < 30) ? 2'b10 : 2'b01)) bad++;
        end
        chk("sync shape", bad, 0);
      end
      wait_idle(2000);
      chk("single rx count", rx_q.size(), 1);
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        chk("tbl word", r.w, tbl[i].d);
        chk("tbl sync", r.c, tbl[i].u);
        chk("tbl parity", r.p, tbl[i].p);
        chk("tbl manchester", r.cok & r.sok, 1);
      end
      chk("tbl run len", last_run, 400);
      chk("tbl gap len", gap_busy, 80);
      exp_q.delete();
      rx_q.delete();
    end

    // back-to-back message
    push(16'h0000, 1'b1);
    push(16'hFFFF, 1'b0);
    push(16'hA5A5, 1'b0);
    wait_idle(4000);
    chk("b2b run len", last_run, 1200);
    drain(3);

    // random words, FIFO driven full
    saw_full = 0;
    for (int i = 0; i < 32; i++)
      push(16'($urandom), 1'($urandom_range(1)));
    wait_idle(40000);
    chk("fifo reached full", saw_full, 1);
    chk("random run len", last_run, 32 * 400);
    drain(32);

    // reset in the middle of a word
    push(16'h1111, 1'b1);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    wait_drv(100);
    repeat (170) @(negedge clk);
    chk("pre-rst driven", drv(data), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst bus", drv(data), 0);
    chk("rst count", fifo_count, 0);
    chk("rst tready", bus.s_axis_tready, 1);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (drv(data) || busy) bad++;
    end
    chk("post-rst quiet", bad, 0);
    rx_q.delete();

    // word pushed during the gap waits it out
    push(16'hC3C3, 1'b1);
    wait_drv(100);
    wait_rel(1000);
    repeat (20) @(negedge clk);
    chk("in gap busy", busy, 1);
    push(16'h5A5A, 1'b0);
    wait_idle(3000);
    chk("gap before next",
        32'(last_gap >= 80 && last_gap <= 82), 1);
    drain(2);

`ifdef MIL_STD_1553_TX_LOOPBACK_CHECK_EN
    push(16'hFFFF, 1'b1);
    push(16'h0F0F, 1'b0);
    push(16'h1357, 1'b0);
    wait_drv(100);
    repeat (160) @(negedge clk);
    force data[0] = 1'b0;
    bad = 0;
    while (!loopback_err && bad < 25) begin
      @(negedge clk);
      bad++;
    end
    release data[0];
    chk("loopback err", loopback_err, 1);
    @(negedge clk);
    chk("abort bus", drv(data), 0);
    void'(exp_q.pop_front());
    rx_q.delete();
    wait_idle(4000);
    drain(2);
    chk("loopback sticky", loopback_err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
